// File: rtl/serial_bus_master.sv
// serial_bus_master: initiator end of the on-chip serial bus (16-bit address, 8-bit data, LSB first).
// Define SERIAL_BUS_MASTER_TIMEOUT_EN to build the ACK_TIMEOUT abort on the AACK/WACK waits.
module serial_bus_master #(
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        M_START,
  input  logic        M_RW,
  input  logic [15:0] M_ADDR,
  input  logic [7:0]  M_DIN,
  output logic [7:0]  M_DOUT,
  output logic        M_DVALID,
  output logic        M_DONE,
  output logic        M_ERR,
  output logic        M_BUSY,
  output logic        B_REQ,
  input  logic        B_GRANT,
  output logic        B_RW,
  output logic        B_VALID,
  output logic        B_BUS_OUT,
  input  logic        B_BUS_IN,
  input  logic        B_ACK
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_REQ   = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_AACK  = 4'd3;
  localparam logic [3:0] S_WDATA = 4'd4;
  localparam logic [3:0] S_WACK  = 4'd5;
  localparam logic [3:0] S_RDATA = 4'd6;
  localparam logic [3:0] S_DONE  = 4'd7;
  localparam logic [3:0] S_ABORT = 4'd8;

  logic [3:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        rw_q, rw_d;

  logic [7:0]  dout_q, dout_d;
  logic        dvalid_q, dvalid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        breq_q, breq_d;
  logic        brw_q, brw_d;
  logic        bvalid_q, bvalid_d;
  logic        bout_q, bout_d;

`ifdef SERIAL_BUS_MASTER_TIMEOUT_EN
  localparam int unsigned WCNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(ACK_TIMEOUT - 1);
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
`else
  // ACK_TIMEOUT has no effect when the timeout is not built
  if (ACK_TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  // Next-state logic; grant loss during a transfer always wins over progress
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rw_d    = rw_q;
    shreg_d = shreg_q;
`ifdef SERIAL_BUS_MASTER_TIMEOUT_EN
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (M_START) begin
          addr_d  = M_ADDR;
          din_d   = M_DIN;
          rw_d    = M_RW;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (B_GRANT) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (!B_GRANT)            state_d = S_ABORT;
        else if (cnt_q == 4'd15) state_d = S_AACK;
        else                     cnt_d   = cnt_q + 4'd1;
      end
      S_AACK: begin
        if (!B_GRANT)  state_d = S_ABORT;
        else if (B_ACK) state_d = rw_q ? S_WDATA : S_RDATA;
`ifdef SERIAL_BUS_MASTER_TIMEOUT_EN
        else if (wcnt_q == WCNT_LIMIT) state_d = S_ABORT;
        else wcnt_d = wcnt_q + WCNT_W'(1);
`endif
      end
      S_WDATA: begin
        if (!B_GRANT)           state_d = S_ABORT;
        else if (cnt_q == 4'd7) state_d = S_WACK;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      S_WACK: begin
        if (!B_GRANT)   state_d = S_ABORT;
        else if (B_ACK) state_d = S_DONE;
`ifdef SERIAL_BUS_MASTER_TIMEOUT_EN
        else if (wcnt_q == WCNT_LIMIT) state_d = S_ABORT;
        else wcnt_d = wcnt_q + WCNT_W'(1);
`endif
      end
      S_RDATA: begin
        if (!B_GRANT) begin
          state_d = S_ABORT;
        end else begin
          shreg_d[cnt_q[2:0]] = B_BUS_IN;
          if (cnt_q == 4'd7) state_d = S_DONE;
          else               cnt_d   = cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Counters restart on every state entry so they can never wrap inside a state
    if (state_d != state_q) begin
      cnt_d  = 4'd0;
`ifdef SERIAL_BUS_MASTER_TIMEOUT_EN
      wcnt_d = '0;
`endif
    end
  end

  // Outputs are registered, so they are decoded from the state being entered
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    breq_d   = 1'b0;
    brw_d    = 1'b0;
    bvalid_d = 1'b0;
    bout_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    dvalid_d = 1'b0;
    dout_d   = dout_q;
    case (state_d)
      S_REQ: breq_d = 1'b1;
      S_ADDR: begin
        breq_d   = 1'b1;
        brw_d    = rw_q;
        bvalid_d = 1'b1;
        bout_d   = addr_q[cnt_d];
      end
      S_AACK, S_WACK, S_RDATA: begin
        breq_d = 1'b1;
        brw_d  = rw_q;
      end
      S_WDATA: begin
        breq_d = 1'b1;
        brw_d  = rw_q;
        bout_d = din_q[cnt_d[2:0]];
      end
      S_DONE: begin
        done_d = 1'b1;
        if (!rw_q) begin
          dvalid_d = 1'b1;
          dout_d   = shreg_d;
        end
      end
      S_ABORT: err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      dout_q   <= 8'h00;
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      breq_q   <= 1'b0;
      brw_q    <= 1'b0;
      bvalid_q <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      breq_q   <= breq_d;
      brw_q    <= brw_d;
      bvalid_q <= bvalid_d;
      bout_q   <= bout_d;
    end
  end

`ifdef SERIAL_BUS_MASTER_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) wcnt_q <= '0;
    else     wcnt_q <= wcnt_d;
  end
`endif

  // Request latches and the read shift register carry data only
  always_ff @(posedge CLK) begin
    addr_q  <= addr_d;
    din_q   <= din_d;
    rw_q    <= rw_d;
    shreg_q <= shreg_d;
  end

  assign M_DOUT    = dout_q;
  assign M_DVALID  = dvalid_q;
  assign M_DONE    = done_q;
  assign M_ERR     = err_q;
  assign M_BUSY    = busy_q;
  assign B_REQ     = breq_q;
  assign B_RW      = brw_q;
  assign B_VALID   = bvalid_q;
  assign B_BUS_OUT = bout_q;

endmodule

// File: tb/tb_serial_bus_master.sv
// Directed bench for serial_bus_master: table of whole transactions plus hand-written corner sequences.
module tb_serial_bus_master;
  logic        CLK = 1'b0;
  logic        RST, M_START, M_RW, B_GRANT, B_BUS_IN, B_ACK;
  logic [15:0] M_ADDR;
  logic [7:0]  M_DIN, M_DOUT;
  logic        M_DVALID, M_DONE, M_ERR, M_BUSY, B_REQ, B_RW, B_VALID, B_BUS_OUT;

  serial_bus_master #(.ACK_TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .M_START(M_START), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_DIN(M_DIN),
    .M_DOUT(M_DOUT), .M_DVALID(M_DVALID), .M_DONE(M_DONE), .M_ERR(M_ERR), .M_BUSY(M_BUSY),
    .B_REQ(B_REQ), .B_GRANT(B_GRANT), .B_RW(B_RW), .B_VALID(B_VALID), .B_BUS_OUT(B_BUS_OUT),
    .B_BUS_IN(B_BUS_IN), .B_ACK(B_ACK)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [7:0]  rdata;
    int          ack_wait;
    logic        noise;
    logic [7:0]  exp_dout;
    int          exp_done;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    RST = 1'b1; M_START = 1'b0; B_ACK = 1'b0; B_BUS_IN = 1'b0;
    ticks(2);
    RST = 1'b0;
  endtask

  // Runs one request from cycle 0 (start) with grant held; cycle numbers follow the documented timing
  task automatic run_vec(input int idx, input vec_t v);
    int w, dc, d0, done_at, err_seen, valid_bad, line_bad, rw_bad;
    logic [15:0] acap;
    logic [7:0]  dcap;
    logic        ev, er;
    w = v.ack_wait; dc = v.exp_done; d0 = 19 + w;
    done_at = -1; err_seen = 0; valid_bad = 0; line_bad = 0; rw_bad = 0;
    acap = '0; dcap = '0;
    M_START = 1'b1; M_RW = v.rw; M_ADDR = v.addr; M_DIN = v.din;
    B_GRANT = 1'b1; B_ACK = 1'b0; B_BUS_IN = 1'b0;
    tick();
    M_RW = ~v.rw; M_ADDR = ~v.addr; M_DIN = ~v.din;
    chk($sformatf("v%0d_req_busy", idx), {30'd0, M_BUSY, B_REQ}, 32'd3);
    for (int c = 1; c <= dc + 2; c++) begin
      ev = (c >= 2 && c <= 17);
      er = v.rw && c >= 2 && c < dc;
      if (B_VALID !== ev) valid_bad++;
      if (B_RW !== er) rw_bad++;
      if (ev) acap[c-2] = B_BUS_OUT;
      else if (v.rw && c >= d0 && c < d0 + 8) dcap[c-d0] = B_BUS_OUT;
      else if (B_BUS_OUT !== 1'b0) line_bad++;
      if (M_DONE === 1'b1 && done_at < 0) done_at = c;
      if (M_ERR !== 1'b0) err_seen++;
      if (c == dc) begin
        chk($sformatf("v%0d_dvalid", idx), {31'd0, M_DVALID}, {31'd0, ~v.rw});
        chk($sformatf("v%0d_dout", idx), {24'd0, M_DOUT}, {24'd0, v.exp_dout});
        chk($sformatf("v%0d_breq_done", idx), {31'd0, B_REQ}, 32'd0);
      end
      if (c == dc + 1) chk($sformatf("v%0d_busy_fall", idx), {30'd0, M_BUSY, M_DONE}, 32'd0);
      if (c == dc + 2) chk($sformatf("v%0d_still_idle", idx), {30'd0, M_BUSY, B_REQ}, 32'd0);
      M_START  = v.noise && (c == 10 || c == dc);
      B_ACK    = (c >= 2 && c <= 17) || (c == 18 + w) || (v.rw && c == 27 + 2 * w);
      B_BUS_IN = (!v.rw && c >= d0 && c < d0 + 8) ? v.rdata[c-d0] : 1'b1;
      tick();
    end
    M_START = 1'b0; B_ACK = 1'b0; B_BUS_IN = 1'b0;
    chk($sformatf("v%0d_addr_stream", idx), {16'd0, acap}, {16'd0, v.addr});
    chk($sformatf("v%0d_valid_window", idx), valid_bad, 0);
    chk($sformatf("v%0d_brw", idx), rw_bad, 0);
    chk($sformatf("v%0d_line_idle", idx), line_bad, 0);
    chk($sformatf("v%0d_done_cycle", idx), done_at, dc);
    chk($sformatf("v%0d_no_err", idx), err_seen, 0);
    if (v.rw) chk($sformatf("v%0d_data_stream", idx), {24'd0, dcap}, {24'd0, v.din});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    vecs[0] = '{1'b1, 16'h1234, 8'hA5, 8'h00, 0, 1'b0, 8'h00, 28};
    vecs[1] = '{1'b0, 16'h0FFC, 8'h00, 8'h3C, 0, 1'b0, 8'h3C, 27};
    vecs[2] = '{1'b1, 16'hFFFF, 8'h5A, 8'h00, 2, 1'b1, 8'h3C, 32};
    vecs[3] = '{1'b0, 16'h8001, 8'h00, 8'h81, 3, 1'b1, 8'h81, 30};
    vecs[4] = '{1'b1, 16'h0000, 8'hFF, 8'h00, 0, 1'b0, 8'h81, 28};

    RST = 1'b1; M_START = 1'b0; M_RW = 1'b0; M_ADDR = '0; M_DIN = '0;
    B_GRANT = 1'b0; B_BUS_IN = 1'b0; B_ACK = 1'b0;
    ticks(3);
    chk("reset_outputs", {16'd0, M_DOUT, M_DVALID, M_DONE, M_ERR, M_BUSY, B_REQ, B_RW, B_VALID, B_BUS_OUT}, 32'd0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Grant arrives late, then is pulled during address bit 7
    M_START = 1'b1; M_RW = 1'b1; M_ADDR = 16'h5ABC; M_DIN = 8'h11; B_GRANT = 1'b0;
    tick();
    M_START = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) chk("a_no_valid_in_req", {30'd0, B_VALID, B_REQ}, 32'd1);
      B_GRANT = (c == 6);
      tick();
    end
    chk("a_first_bit_c7", {30'd0, B_VALID, B_BUS_OUT}, 32'd2);
    ticks(7);
    chk("a_bit7_c14", {29'd0, B_VALID, B_BUS_OUT, M_ERR}, 32'd6);
    B_GRANT = 1'b0;
    tick();
    chk("a_abort_c15", {16'd0, M_DOUT, M_ERR, M_DONE, M_BUSY, B_REQ, B_RW, B_VALID, B_BUS_OUT, M_DVALID},
        {16'd0, 8'h81, 8'b1010_0000});
    tick();
    chk("a_idle_c16", {30'd0, M_BUSY, M_ERR}, 32'd0);
    B_GRANT = 1'b1;

    // Read to completion, then a new start in the first non-busy cycle
    M_START = 1'b1; M_RW = 1'b0; M_ADDR = 16'h00F0;
    tick();
    M_START = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      B_ACK = (c == 18);
      B_BUS_IN = (c >= 19) ? bit'(8'h5E >> (c - 19)) : 1'b0;
      tick();
    end
    B_ACK = 1'b0;
    chk("d_read_done", {22'd0, M_DOUT, M_DONE, M_DVALID}, {22'd0, 8'h5E, 2'b11});
    tick();
    chk("d_busy_low_c28", {31'd0, M_BUSY}, 32'd0);
    M_START = 1'b1; M_RW = 1'b1; M_ADDR = 16'h4321;
    tick();
    M_START = 1'b0;
    chk("d_back_to_back", {30'd0, M_BUSY, B_REQ}, 32'd3);
    tick();
    B_GRANT = 1'b0;
    tick();
    chk("d_abort_keeps_dout", {23'd0, M_DOUT, M_ERR}, {23'd0, 8'h5E, 1'b1});
    tick();
    B_GRANT = 1'b1;

    // Reset in RDATA bit 4, with starts issued while busy
    M_START = 1'b1; M_RW = 1'b0; M_ADDR = 16'h0FFC;
    tick();
    M_START = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      M_START = (c == 5 || c == 12 || c == 20);
      M_ADDR = 16'h7777;
      B_ACK = (c == 18);
      B_BUS_IN = 1'b1;
      tick();
    end
    M_START = 1'b1; B_ACK = 1'b0;
    chk("c_busy_before_rst", {22'd0, M_DOUT, M_BUSY, B_REQ}, {22'd0, 8'h5E, 2'b11});
    RST = 1'b1;
    tick();
    M_START = 1'b0; RST = 1'b0;
    chk("c_reset_outputs", {16'd0, M_DOUT, M_DVALID, M_DONE, M_ERR, M_BUSY, B_REQ, B_RW, B_VALID, B_BUS_OUT}, 32'd0);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      if ({M_BUSY, B_REQ, M_DONE, M_ERR} !== 4'd0) bad++;
      tick();
    end
    chk("c_no_second_txn", bad, 0);

    // Slave never acknowledges the address
    M_START = 1'b1; M_RW = 1'b0; M_ADDR = 16'h0100; B_GRANT = 1'b1; B_ACK = 1'b0;
    tick();
    M_START = 1'b0;
    ticks(17);
    chk("b_in_aack_c18", {30'd0, B_REQ, B_VALID}, 32'd2);
`ifdef SERIAL_BUS_MASTER_TIMEOUT_EN
    ticks(7);
    chk("b_no_err_c25", {30'd0, M_ERR, M_BUSY}, 32'd1);
    tick();
    chk("b_timeout_err_c26", {30'd0, M_ERR, B_REQ}, 32'd2);
    tick();
    chk("b_idle_c27", {30'd0, M_BUSY, M_ERR}, 32'd0);
`else
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (M_ERR !== 1'b0) bad++;
    end
    chk("b_still_waiting", {30'd0, M_BUSY, B_REQ}, 32'd3);
    chk("b_no_err", bad, 0);
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
